hwpe_ctrl_offload_master: RTL and testbench

HWPE_CTRL_OFFLOAD_MASTER -- requirements
Module: hwpe_ctrl_offload_master

---
 rtl/hwpe_ctrl_offload_master.sv | 208 ++++++++++++++++++++
 tb/tb_hwpe_ctrl_offload_master.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_offload_master.sv
// ---------------------------------------------------------------------------
// hwpe_ctrl_offload_master
//
// Offloads one job to an HWPE control slave over a req/gnt peripheral port:
// acquires a context (retrying with a fixed back-off while the slave is full),
// writes the latched job registers, triggers the job and waits for the
// completion event.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous soft clear (same effect as reset)
//   job_valid_i/ready_o    job handshake; job_regs_i is the descriptor
//   evt_i                  completion event from the slave (1-cycle pulse)
//   busy_o                 high whenever not idle
//   done_o, abort_o        1-cycle completion / acquire-abort pulses
//   ctx_id_o               context id returned by the ACQUIRE read
//   periph_*_o / periph_*_i  peripheral master port (wen: 1=read, 0=write)
// ---------------------------------------------------------------------------
module hwpe_ctrl_offload_master #(
    parameter int unsigned N_JOB_REGS     = 8,
    parameter int unsigned ID_WIDTH       = 16,
    parameter int unsigned MASTER_ID      = 0,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter logic [31:0] JOB_REG_OFFS   = 32'h40,
    parameter int unsigned BACKOFF_CYCLES = 8,
    parameter int unsigned MAX_RETRIES    = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    input  logic                            job_valid_i,
    output logic                            job_ready_o,
    input  logic [N_JOB_REGS-1:0][31:0]     job_regs_i,
    input  logic                            evt_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            abort_o,
    output logic [7:0]                      ctx_id_o,
    output logic                            periph_req_o,
    output logic [31:0]                     periph_add_o,
    output logic                            periph_wen_o,
    output logic [3:0]                      periph_be_o,
    output logic [31:0]                     periph_data_o,
    output logic [ID_WIDTH-1:0]             periph_id_o,
    input  logic                            periph_gnt_i,
    input  logic [31:0]                     periph_r_data_i,
    input  logic                            periph_r_valid_i,
    input  logic [ID_WIDTH-1:0]             periph_r_id_i
);

    localparam int unsigned K_W  = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;
    localparam int unsigned BO_W = $clog2(BACKOFF_CYCLES + 1);

    localparam logic [31:0]         ACQUIRE_ADDR = BASE_ADDR + 32'h4;
    localparam logic [31:0]         TRIGGER_ADDR = BASE_ADDR;
    localparam logic [31:0]         JOB_ADDR     = BASE_ADDR + JOB_REG_OFFS;
    localparam logic [ID_WIDTH-1:0] MY_ID        = ID_WIDTH'(MASTER_ID);
    localparam logic [K_W-1:0]      K_LAST       = K_W'(N_JOB_REGS - 1);
    localparam logic [BO_W-1:0]     BO_LAST      = BO_W'(BACKOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, ACQ_REQ, ACQ_WAIT, BACKOFF, WRITE, TRIGGER, WAIT_EVT
    } state_e;

    state_e                      state_q, state_d;
    logic [7:0]                  retry_q, retry_d;
    logic [BO_W-1:0]             bo_cnt_q, bo_cnt_d;
    logic [K_W-1:0]              k_q, k_d;
    logic [7:0]                  ctx_q, ctx_d;
    logic [N_JOB_REGS-1:0][31:0] job_q, job_d;
    logic                        done_q, done_d;
    logic                        abort_q, abort_d;

    logic [7:0]                  retry_inc;
    logic                        resp_hit;

    // Saturating increment of the retry count.
    assign retry_inc = (retry_q == 8'hFF) ? 8'hFF : retry_q + 8'd1;
    assign resp_hit  = periph_r_valid_i && (periph_r_id_i == MY_ID);

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        retry_d       = retry_q;
        bo_cnt_d      = bo_cnt_q;
        k_d           = k_q;
        ctx_d         = ctx_q;
        job_d         = job_q;
        done_d        = 1'b0;
        abort_d       = 1'b0;
        periph_req_o  = 1'b0;
        periph_add_o  = 32'h0;
        periph_wen_o  = 1'b0;
        periph_be_o   = 4'h0;
        periph_data_o = 32'h0;

        // Request fields are functions of registered state only, so they
        // cannot change while a request waits for gnt.
        unique case (state_q)
            IDLE: begin
                if (job_valid_i) begin
                    job_d   = job_regs_i;
                    retry_d = 8'd0;
                    state_d = ACQ_REQ;
                end
            end
            ACQ_REQ: begin
                periph_req_o = 1'b1;
                periph_add_o = ACQUIRE_ADDR;
                periph_wen_o = 1'b1;
                periph_be_o  = 4'hF;
                if (periph_gnt_i) state_d = ACQ_WAIT;
            end
            ACQ_WAIT: begin
                if (resp_hit) begin
                    if (!periph_r_data_i[31]) begin
                        ctx_d   = periph_r_data_i[7:0];
                        k_d     = '0;
                        state_d = WRITE;
                    end else begin
                        retry_d = retry_inc;
                        if (32'(retry_inc) >= MAX_RETRIES) begin
                            abort_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            bo_cnt_d = '0;
                            state_d  = BACKOFF;
                        end
                    end
                end
            end
            BACKOFF: begin
                if (bo_cnt_q == BO_LAST) state_d  = ACQ_REQ;
                else                     bo_cnt_d = bo_cnt_q + 1'b1;
            end
            WRITE: begin
                periph_req_o  = 1'b1;
                periph_add_o  = JOB_ADDR + (32'(k_q) << 2);
                periph_be_o   = 4'hF;
                periph_data_o = job_q[k_q];
                if (periph_gnt_i) begin
                    if (k_q == K_LAST) state_d = TRIGGER;
                    else               k_d     = k_q + 1'b1;
                end
            end
            TRIGGER: begin
                periph_req_o = 1'b1;
                periph_add_o = TRIGGER_ADDR;
                periph_be_o  = 4'hF;
                if (periph_gnt_i) state_d = WAIT_EVT;
            end
            WAIT_EVT: begin
                if (evt_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Soft clear wins over everything, including a pending request.
        if (clear_i) begin
            state_d  = IDLE;
            retry_d  = 8'd0;
            bo_cnt_d = '0;
            k_d      = '0;
            ctx_d    = 8'd0;
            job_d    = '0;
            done_d   = 1'b0;
            abort_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            retry_q  <= 8'd0;
            bo_cnt_q <= '0;
            k_q      <= '0;
            ctx_q    <= 8'd0;
            // NOTE: the latched job is a small register file, not a RAM, and
            // it is cleared on reset so no stale descriptor survives.
            job_q    <= '0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            retry_q  <= retry_d;
            bo_cnt_q <= bo_cnt_d;
            k_q      <= k_d;
            ctx_q    <= ctx_d;
            job_q    <= job_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
        end
    end

    assign job_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign abort_o     = abort_q;
    assign ctx_id_o    = ctx_q;
    assign periph_id_o = periph_req_o ? MY_ID : '0;

endmodule

// File: tb/tb_hwpe_ctrl_offload_master.sv
`timescale 1ns/1ps
module tb_hwpe_ctrl_offload_master;

    localparam int MASTER_ID = 0;

    logic             clk = 1'b0;
    logic             rst_n, clear, job_valid, evt, gnt, r_valid;
    logic [1:0][31:0] job_regs;
    logic [31:0]      r_data;
    logic [15:0]      r_id;

    logic        job_ready, busy, done, abort, req, wen;
    logic [7:0]  ctx;
    logic [31:0] add, data;
    logic [3:0]  be;
    logic [15:0] pid;

    logic        job_ready2, busy2, done2, abort2, req2, wen2;
    logic [7:0]  ctx2;
    logic [31:0] add2, data2;
    logic [3:0]  be2;
    logic [15:0] pid2;

    always #5 clk = ~clk;

    hwpe_ctrl_offload_master #(.N_JOB_REGS(2), .MASTER_ID(MASTER_ID)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .job_valid_i(job_valid), .job_ready_o(job_ready), .job_regs_i(job_regs),
        .evt_i(evt), .busy_o(busy), .done_o(done), .abort_o(abort), .ctx_id_o(ctx),
        .periph_req_o(req), .periph_add_o(add), .periph_wen_o(wen), .periph_be_o(be),
        .periph_data_o(data), .periph_id_o(pid), .periph_gnt_i(gnt),
        .periph_r_data_i(r_data), .periph_r_valid_i(r_valid), .periph_r_id_i(r_id)
    );

    // Same stimulus, but aborts after the second rejected acquire.
    hwpe_ctrl_offload_master #(.N_JOB_REGS(2), .MASTER_ID(MASTER_ID), .MAX_RETRIES(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .job_valid_i(job_valid), .job_ready_o(job_ready2), .job_regs_i(job_regs),
        .evt_i(evt), .busy_o(busy2), .done_o(done2), .abort_o(abort2), .ctx_id_o(ctx2),
        .periph_req_o(req2), .periph_add_o(add2), .periph_wen_o(wen2), .periph_be_o(be2),
        .periph_data_o(data2), .periph_id_o(pid2), .periph_gnt_i(gnt),
        .periph_r_data_i(r_data), .periph_r_valid_i(r_valid), .periph_r_id_i(r_id)
    );

    typedef struct { logic v; logic [15:0] id; logic [31:0] data; logic last; } resp_t;
    typedef struct { logic [31:0] acq; logic [31:0] j0; logic [31:0] j1; logic [7:0] ctx; } vec_t;

    int n_checks = 0, n_pass = 0;
    logic [31:0] wr_addr[$], wr_data[$];
    int          gaps[$];
    resp_t       resp_q[$];
    int          rd_cnt, rd2_cnt, wr2_cnt, done_cnt, abort_cnt, abort2_cnt, bad_rd;
    int          low_run;
    bit          counting, emitting;
    logic [31:0] default_resp;
    logic        samp_req;
    logic [31:0] samp_add, samp_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic reset_logs();
        wr_addr.delete(); wr_data.delete(); gaps.delete(); resp_q.delete();
        rd_cnt = 0; rd2_cnt = 0; wr2_cnt = 0; done_cnt = 0; abort_cnt = 0;
        abort2_cnt = 0; bad_rd = 0; low_run = 0; counting = 0; emitting = 0;
    endtask

    // One clock cycle: observe on the falling edge, drive after the rising edge.
    // The slave answers a granted read in the following cycle(s).
    task automatic tick();
        resp_t e;
        @(negedge clk);
        samp_req = req; samp_add = add; samp_data = data;
        if (req && gnt) begin
            if (wen) begin
                rd_cnt++;
                if (add !== 32'h4 || be !== 4'hF || pid !== 16'(MASTER_ID)) bad_rd++;
                emitting = 1;
            end else begin
                wr_addr.push_back(add);
                wr_data.push_back(data);
            end
        end
        if (req2 && gnt) begin
            if (wen2) rd2_cnt++;
            else      wr2_cnt++;
        end
        done_cnt   += int'(done);
        abort_cnt  += int'(abort);
        abort2_cnt += int'(abort2);
        if (r_valid) begin
            counting = 1; low_run = 0;
        end else if (counting) begin
            if (req) begin gaps.push_back(low_run); counting = 0; end
            else low_run++;
        end
        @(posedge clk); #1;
        r_valid = 0; evt = 0; job_valid = 0; clear = 0;
        if (emitting) begin
            if (resp_q.size() > 0) begin
                e = resp_q.pop_front();
                r_valid = e.v; r_id = e.id; r_data = e.data;
                if (e.last) emitting = 0;
            end else begin
                r_valid = 1; r_id = 16'(MASTER_ID); r_data = default_resp; emitting = 0;
            end
        end
    endtask

    task automatic do_reset();
        #1 rst_n = 0;
        clear = 0; job_valid = 0; evt = 0; gnt = 1; r_valid = 0;
        r_data = 0; r_id = 0; job_regs = '0; default_resp = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        reset_logs();
    endtask

    task automatic push_resp(input logic v, input logic [15:0] id, input logic [31:0] d,
                             input logic last);
        resp_t e;
        e.v = v; e.id = id; e.data = d; e.last = last;
        resp_q.push_back(e);
    endtask

    task automatic start_job(input logic [31:0] j0, input logic [31:0] j1);
        job_regs[0] = j0; job_regs[1] = j1; job_valid = 1;
        tick();
        job_regs = {32'hDEAD_0001, 32'hDEAD_0000};  // must not leak into the writes
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        int c = 0;
        while (wr_addr.size() < n && c < budget) begin tick(); c++; end
        if (wr_addr.size() < n) check({tag, "_timeout"}, wr_addr.size(), n);
    endtask

    task automatic check_job(input string tag, input logic [31:0] j0, input logic [31:0] j1);
        check({tag, "_nwr"}, wr_addr.size(), 3);
        if (wr_addr.size() == 3) begin
            check({tag, "_a0"}, wr_addr[0], 32'h40);
            check({tag, "_d0"}, wr_data[0], j0);
            check({tag, "_a1"}, wr_addr[1], 32'h44);
            check({tag, "_d1"}, wr_data[1], j1);
            check({tag, "_a2"}, wr_addr[2], 32'h00);
            check({tag, "_d2"}, wr_data[2], 32'h0);
        end
    endtask

    task automatic finish_job(input string tag);
        evt = 1;
        tick();
        repeat (3) tick();
        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, job_ready, 1);
    endtask

    vec_t vecs[4];

    initial begin
        bit stable;
        string t;
        int c;

        vecs[0] = '{acq: 32'h0000_0003, j0: 32'h1111_2222, j1: 32'h3333_4444, ctx: 8'h03};
        vecs[1] = '{acq: 32'h7FFF_FF5A, j0: 32'hA5A5_A5A5, j1: 32'h5A5A_5A5A, ctx: 8'h5A};
        vecs[2] = '{acq: 32'h0000_01C1, j0: 32'hFFFF_FFFF, j1: 32'h0000_0000, ctx: 8'hC1};
        vecs[3] = '{acq: 32'h0000_00FF, j0: 32'h0000_0001, j1: 32'h8000_0000, ctx: 8'hFF};

        rst_n = 1;
        do_reset();
        check("rst_ready", job_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_req", req, 0);
        check("rst_done_abort", {done, abort}, 0);
        check("rst_ctx", ctx, 0);
        check("rst_add_id", {add[15:0], pid}, 0);

        // Table-driven jobs: one accepted acquire, two job writes, trigger, event.
        for (int i = 0; i < 4; i++) begin
            t = $sformatf("vec%0d", i);
            do_reset();
            push_resp(1, 16'(MASTER_ID), vecs[i].acq, 1);
            start_job(vecs[i].j0, vecs[i].j1);
            check({t, "_busy_run"}, busy, 1);
            wait_writes(3, 30, t);
            check_job(t, vecs[i].j0, vecs[i].j1);
            check({t, "_ctx"}, ctx, vecs[i].ctx);
            check({t, "_rd"}, rd_cnt, 1);
            check({t, "_rdfmt"}, bad_rd, 0);
            finish_job(t);
        end

        // Two rejected acquires, then success: 8 request-low cycles after each rejection.
        do_reset();
        push_resp(1, 16'(MASTER_ID), 32'hFFFF_FFFF, 1);
        push_resp(1, 16'(MASTER_ID), 32'hFFFF_FFFF, 1);
        push_resp(1, 16'(MASTER_ID), 32'h0000_0000, 1);
        start_job(32'hCAFE_0000, 32'hCAFE_0001);
        wait_writes(3, 60, "retry");
        check("retry_rd", rd_cnt, 3);
        check("retry_ngaps", gaps.size(), 3);
        if (gaps.size() == 3) begin
            check("retry_gap0", gaps[0], 8);
            check("retry_gap1", gaps[1], 8);
            check("retry_gap2", gaps[2], 0);
        end
        check_job("retry", 32'hCAFE_0000, 32'hCAFE_0001);
        finish_job("retry");

        // Acquire always negative: dut2 gives up after two reads.
        do_reset();
        start_job(32'h1, 32'h2);
        repeat (40) tick();
        check("abort_rd", rd2_cnt, 2);
        check("abort_pulse", abort2_cnt, 1);
        check("abort_wr", wr2_cnt, 0);
        check("abort_idle", {job_ready2, busy2}, 2'b10);
        check("abort_main_keeps_trying", abort_cnt, 0);

        // gnt low for 5 cycles on job register 1.
        do_reset();
        push_resp(1, 16'(MASTER_ID), 32'h0000_0009, 1);
        start_job(32'hBEEF_0000, 32'hBEEF_0001);
        wait_writes(1, 30, "stall");
        gnt = 0;
        stable = 1;
        repeat (5) begin
            tick();
            if (samp_req !== 1'b1 || samp_add !== 32'h44 || samp_data !== 32'hBEEF_0001)
                stable = 0;
        end
        check("stall_stable", stable, 1);
        check("stall_nwr_held", wr_addr.size(), 1);
        gnt = 1;
        wait_writes(3, 10, "stall");
        check_job("stall", 32'hBEEF_0000, 32'hBEEF_0001);
        finish_job("stall");

        // Response carrying a foreign id is ignored.
        do_reset();
        push_resp(1, 16'(MASTER_ID + 1), 32'h0000_0000, 0);
        push_resp(0, 16'h0, 32'h0, 0);
        push_resp(1, 16'(MASTER_ID), 32'h0000_0007, 1);
        start_job(32'h0BAD_0000, 32'h0BAD_0001);
        wait_writes(3, 30, "rid");
        check("rid_ctx", ctx, 8'h07);
        check("rid_rd", rd_cnt, 1);
        check_job("rid", 32'h0BAD_0000, 32'h0BAD_0001);

        // Asynchronous reset in the middle of the job writes.
        do_reset();
        push_resp(1, 16'(MASTER_ID), 32'h0000_0004, 1);
        start_job(32'h5555_0000, 32'h5555_0001);
        wait_writes(1, 30, "rstmid");
        rst_n = 0;
        #1;
        check("rstmid_req", req, 0);
        check("rstmid_ready", job_ready, 1);
        check("rstmid_ctx", ctx, 0);
        tick();
        rst_n = 1;
        reset_logs();
        push_resp(1, 16'(MASTER_ID), 32'h0000_0006, 1);
        start_job(32'h6666_0000, 32'h6666_0001);
        wait_writes(3, 30, "rstmid2");
        check("rstmid2_rd", rd_cnt, 1);
        check_job("rstmid2", 32'h6666_0000, 32'h6666_0001);

        // Soft clear drops an ungranted acquire request.
        do_reset();
        gnt = 0;
        start_job(32'h1, 32'h2);
        tick();
        check("clr_req_before", req, 1);
        clear = 1;
        tick();
        check("clr_req", req, 0);
        check("clr_idle", {job_ready, busy}, 2'b10);
        gnt = 1;
        c = 0;
        repeat (3) begin tick(); c++; end
        check("clr_no_read", rd_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
